// File: rtl/display_timing_sequencer_pkg.sv
// Shared types and constants for the display timing sequencer: FSM encoding,
// 640x480 power-on timing, config field layout and ctrl word bit positions.
package display_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RUN    = 3'd2,
    ST_PEND   = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // 640x480@60 timing, used at reset for both active and staging registers.
  localparam int DEF_HS_END    = 96;
  localparam int DEF_HBP_END   = 144;
  localparam int DEF_HFP_BEGIN = 784;
  localparam int DEF_HLINE_END = 800;
  localparam int DEF_VS_END    = 2;
  localparam int DEF_VBP_END   = 35;
  localparam int DEF_VFP_BEGIN = 515;
  localparam int DEF_VLINE_END = 525;

  // Field index inside cfg_h / cfg_v; bit offset is index * timing width.
  localparam int F_SYNC_END = 0;
  localparam int F_BP_END   = 1;
  localparam int F_FP_BEGIN = 2;
  localparam int F_LINE_END = 3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_PAT_LSB = 8;
  localparam int CTRL_PAT_W   = 8;

endpackage

// File: rtl/display_timing_sequencer_cfg_check.sv
// Combinational validator for a host timing config: each axis must satisfy
// 0 < sync_end < bp_end < fp_begin <= line_end with line_end >= 2.
module display_cfg_check
  import display_seq_pkg::*;
#(
  parameter int C_TIMING_WIDTH = 12
) (
  input  logic [4*C_TIMING_WIDTH-1:0] cfg_h,
  input  logic [4*C_TIMING_WIDTH-1:0] cfg_v,
  output logic                        valid
);

  localparam int TW = C_TIMING_WIDTH;

  function automatic logic axis_ok(input logic [4*TW-1:0] f);
    logic [TW-1:0] sync_end, bp_end, fp_begin, line_end;
    sync_end = f[F_SYNC_END*TW +: TW];
    bp_end   = f[F_BP_END*TW   +: TW];
    fp_begin = f[F_FP_BEGIN*TW +: TW];
    line_end = f[F_LINE_END*TW +: TW];
    return (sync_end != '0) && (sync_end < bp_end) && (bp_end < fp_begin) &&
           (fp_begin <= line_end) && (line_end >= TW'(2));
  endfunction

  assign valid = axis_ok(cfg_h) && axis_ok(cfg_v);

endmodule

// File: rtl/display_timing_sequencer.sv
// Sequences enable/disable of the pixel-domain timing controller and applies
// validated host timing configs only at frame boundaries (vsync rising edge).
module display_timing_sequencer
  import display_seq_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_TIMING_WIDTH     = 12,
  parameter int C_LOCK_SETTLE      = 16,
  parameter int C_STOP_TIMEOUT     = 2000000
) (
  input  logic                          pix_clk,
  input  logic                          areset,
  input  logic                          pix_clk_locked,
  input  logic                          en_req,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [4*C_TIMING_WIDTH-1:0]   cfg_h,
  input  logic [4*C_TIMING_WIDTH-1:0]   cfg_v,
  input  logic [7:0]                    cfg_pattern,
  input  logic                          vsync,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl,
  output logic [C_S_AXI_DATA_WIDTH-1:0] hs_end,
  output logic [C_S_AXI_DATA_WIDTH-1:0] hbp_end,
  output logic [C_S_AXI_DATA_WIDTH-1:0] hfp_begin,
  output logic [C_S_AXI_DATA_WIDTH-1:0] hline_end,
  output logic [C_S_AXI_DATA_WIDTH-1:0] vs_end,
  output logic [C_S_AXI_DATA_WIDTH-1:0] vbp_end,
  output logic [C_S_AXI_DATA_WIDTH-1:0] vfp_begin,
  output logic [C_S_AXI_DATA_WIDTH-1:0] vline_end,
  output logic [2:0]                    state,
  output logic                          cfg_applied,
  output logic                          cfg_err,
  output logic                          lock_lost,
  output logic [15:0]                   frame_cnt
);

  localparam int TW       = C_TIMING_WIDTH;
  localparam int CW       = 4 * TW;
  localparam int SETTLE_W = (C_LOCK_SETTLE > 1) ? $clog2(C_LOCK_SETTLE) : 1;
  localparam int STOP_W   = (C_STOP_TIMEOUT > 1) ? $clog2(C_STOP_TIMEOUT) : 1;

  localparam logic [CW-1:0] DEF_H = {TW'(DEF_HLINE_END), TW'(DEF_HFP_BEGIN),
                                     TW'(DEF_HBP_END), TW'(DEF_HS_END)};
  localparam logic [CW-1:0] DEF_V = {TW'(DEF_VLINE_END), TW'(DEF_VFP_BEGIN),
                                     TW'(DEF_VBP_END), TW'(DEF_VS_END)};

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(C_LOCK_SETTLE - 1);
  localparam logic [STOP_W-1:0]   STOP_LAST   = STOP_W'(C_STOP_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  vsync_q, vsync_d;
  logic                  ctrl_en_q, ctrl_en_d;
  logic [7:0]            pattern_q, pattern_d;
  logic [CW-1:0]         act_h_q, act_h_d, act_v_q, act_v_d;
  logic [CW-1:0]         stg_h_q, stg_h_d, stg_v_q, stg_v_d;
  logic [7:0]            stg_pat_q, stg_pat_d;
  logic                  pending_q, pending_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [STOP_W-1:0]     stop_cnt_q, stop_cnt_d;
  logic                  applied_q, applied_d;
  logic                  err_q, err_d;
  logic                  lock_lost_q, lock_lost_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  logic cfg_ok;
  logic cfg_fire;
  logic vs_rise;

  display_cfg_check #(
    .C_TIMING_WIDTH(C_TIMING_WIDTH)
  ) u_cfg_check (
    .cfg_h(cfg_h),
    .cfg_v(cfg_v),
    .valid(cfg_ok)
  );

  assign cfg_ready = (state_q == ST_OFF) || (state_q == ST_RUN);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign vs_rise   = vsync && !vsync_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    ctrl_en_d    = ctrl_en_q;
    pattern_d    = pattern_q;
    act_h_d      = act_h_q;
    act_v_d      = act_v_q;
    stg_h_d      = stg_h_q;
    stg_v_d      = stg_v_q;
    stg_pat_d    = stg_pat_q;
    pending_d    = pending_q;
    settle_cnt_d = settle_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    applied_d    = 1'b0;
    err_d        = cfg_fire && !cfg_ok;
    lock_lost_d  = lock_lost_q;
    frame_cnt_d  = frame_cnt_q;
    // Edge detector is held clear while disabled so the first frame after
    // enable is seen as a fresh rising edge.
    vsync_d      = ctrl_en_q && vsync;

    if (vs_rise && (state_q inside {ST_RUN, ST_PEND, ST_STOP}))
      frame_cnt_d = frame_cnt_q + 16'd1;

    // Staging a RUN-state config happens even if lock drops in the same cycle,
    // since the handshake has already completed.
    if (state_q == ST_RUN && cfg_fire && cfg_ok) begin
      stg_h_d   = cfg_h;
      stg_v_d   = cfg_v;
      stg_pat_d = cfg_pattern;
      pending_d = 1'b1;
    end

    if (state_q != ST_OFF && !pix_clk_locked) begin
      state_d     = ST_OFF;
      ctrl_en_d   = 1'b0;
      lock_lost_d = 1'b1;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (cfg_fire && cfg_ok) begin
            act_h_d   = cfg_h;
            act_v_d   = cfg_v;
            pattern_d = cfg_pattern;
            applied_d = 1'b1;
            // A directly applied config supersedes anything still staged.
            pending_d = 1'b0;
          end
          if (en_req && pix_clk_locked) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
            lock_lost_d  = 1'b0;
          end
        end

        ST_SETTLE: begin
          if (!en_req) begin
            state_d = ST_OFF;
          end else if (settle_cnt_q == SETTLE_LAST) begin
            state_d   = ST_RUN;
            ctrl_en_d = 1'b1;
            if (pending_q) begin
              act_h_d   = stg_h_q;
              act_v_d   = stg_v_q;
              pattern_d = stg_pat_q;
              applied_d = 1'b1;
              pending_d = 1'b0;
            end
          end else begin
            settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
          end
        end

        ST_RUN: begin
          if (cfg_fire && cfg_ok) state_d = ST_PEND;
          if (!en_req) begin
            state_d    = ST_STOP;
            stop_cnt_d = '0;
          end
        end

        ST_PEND: begin
          if (vs_rise) begin
            act_h_d   = stg_h_q;
            act_v_d   = stg_v_q;
            pattern_d = stg_pat_q;
            applied_d = 1'b1;
            pending_d = 1'b0;
            state_d   = ST_RUN;
          end
          if (!en_req) begin
            state_d    = ST_STOP;
            stop_cnt_d = '0;
          end
        end

        ST_STOP: begin
          if (vs_rise || stop_cnt_q == STOP_LAST) begin
            ctrl_en_d = 1'b0;
            state_d   = ST_OFF;
          end else if (en_req) begin
            state_d = pending_q ? ST_PEND : ST_RUN;
          end else begin
            stop_cnt_d = stop_cnt_q + STOP_W'(1);
          end
        end

        default: begin
          state_d   = ST_OFF;
          ctrl_en_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge pix_clk or posedge areset) begin
    if (areset) begin
      state_q      <= ST_OFF;
      vsync_q      <= 1'b0;
      ctrl_en_q    <= 1'b0;
      pattern_q    <= '0;
      act_h_q      <= DEF_H;
      act_v_q      <= DEF_V;
      stg_h_q      <= DEF_H;
      stg_v_q      <= DEF_V;
      stg_pat_q    <= '0;
      pending_q    <= 1'b0;
      settle_cnt_q <= '0;
      stop_cnt_q   <= '0;
      applied_q    <= 1'b0;
      err_q        <= 1'b0;
      lock_lost_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      ctrl_en_q    <= ctrl_en_d;
      pattern_q    <= pattern_d;
      act_h_q      <= act_h_d;
      act_v_q      <= act_v_d;
      stg_h_q      <= stg_h_d;
      stg_v_q      <= stg_v_d;
      stg_pat_q    <= stg_pat_d;
      pending_q    <= pending_d;
      settle_cnt_q <= settle_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      applied_q    <= applied_d;
      err_q        <= err_d;
      lock_lost_q  <= lock_lost_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  always_comb begin
    ctrl                                   = '0;
    ctrl[CTRL_EN_BIT]                      = ctrl_en_q;
    ctrl[CTRL_PAT_LSB +: CTRL_PAT_W]       = pattern_q;
  end

  assign hs_end      = C_S_AXI_DATA_WIDTH'(act_h_q[F_SYNC_END*TW +: TW]);
  assign hbp_end     = C_S_AXI_DATA_WIDTH'(act_h_q[F_BP_END*TW   +: TW]);
  assign hfp_begin   = C_S_AXI_DATA_WIDTH'(act_h_q[F_FP_BEGIN*TW +: TW]);
  assign hline_end   = C_S_AXI_DATA_WIDTH'(act_h_q[F_LINE_END*TW +: TW]);
  assign vs_end      = C_S_AXI_DATA_WIDTH'(act_v_q[F_SYNC_END*TW +: TW]);
  assign vbp_end     = C_S_AXI_DATA_WIDTH'(act_v_q[F_BP_END*TW   +: TW]);
  assign vfp_begin   = C_S_AXI_DATA_WIDTH'(act_v_q[F_FP_BEGIN*TW +: TW]);
  assign vline_end   = C_S_AXI_DATA_WIDTH'(act_v_q[F_LINE_END*TW +: TW]);

  assign state       = state_q;
  assign cfg_applied = applied_q;
  assign cfg_err     = err_q;
  assign lock_lost   = lock_lost_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_display_timing_sequencer.sv
// Self-checking bench: directed sequences for enable/settle, frame-boundary
// apply, lock loss, stop timeout and frame counting, plus an OFF-state config table.
module tb_display_timing_sequencer;

  localparam int DW     = 32;
  localparam int TW     = 12;
  localparam int SETTLE = 16;
  localparam int STOPTO = 50;

  localparam logic [2:0] S_OFF = 3'd0, S_SETTLE = 3'd1, S_RUN = 3'd2,
                         S_PEND = 3'd3, S_STOP = 3'd4;

  logic          pix_clk = 1'b0;
  logic          areset;
  logic          pix_clk_locked;
  logic          en_req;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [47:0]   cfg_h;
  logic [47:0]   cfg_v;
  logic [7:0]    cfg_pattern;
  logic          vsync;
  logic [DW-1:0] ctrl;
  logic [DW-1:0] hs_end, hbp_end, hfp_begin, hline_end;
  logic [DW-1:0] vs_end, vbp_end, vfp_begin, vline_end;
  logic [2:0]    state;
  logic          cfg_applied;
  logic          cfg_err;
  logic          lock_lost;
  logic [15:0]   frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  display_timing_sequencer #(
    .C_S_AXI_DATA_WIDTH(DW),
    .C_TIMING_WIDTH    (TW),
    .C_LOCK_SETTLE     (SETTLE),
    .C_STOP_TIMEOUT    (STOPTO)
  ) dut (
    .pix_clk       (pix_clk),
    .areset        (areset),
    .pix_clk_locked(pix_clk_locked),
    .en_req        (en_req),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_h         (cfg_h),
    .cfg_v         (cfg_v),
    .cfg_pattern   (cfg_pattern),
    .vsync         (vsync),
    .ctrl          (ctrl),
    .hs_end        (hs_end),
    .hbp_end       (hbp_end),
    .hfp_begin     (hfp_begin),
    .hline_end     (hline_end),
    .vs_end        (vs_end),
    .vbp_end       (vbp_end),
    .vfp_begin     (vfp_begin),
    .vline_end     (vline_end),
    .state         (state),
    .cfg_applied   (cfg_applied),
    .cfg_err       (cfg_err),
    .lock_lost     (lock_lost),
    .frame_cnt     (frame_cnt)
  );

  always #5 pix_clk = ~pix_clk;

  typedef struct {
    logic [47:0] h;
    logic [47:0] v;
    logic [7:0]  pat;
    logic        ok;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [47:0] pack4(input int line_end, fp_begin, bp_end, sync_end);
    return {12'(line_end), 12'(fp_begin), 12'(bp_end), 12'(sync_end)};
  endfunction

  function automatic logic [255:0] exp_timing(input logic [47:0] h, input logic [47:0] v);
    return {32'(v[47:36]), 32'(v[35:24]), 32'(v[23:12]), 32'(v[11:0]),
            32'(h[47:36]), 32'(h[35:24]), 32'(h[23:12]), 32'(h[11:0])};
  endfunction

  function automatic logic [255:0] timing_now();
    return {vline_end, vfp_begin, vbp_end, vs_end,
            hline_end, hfp_begin, hbp_end, hs_end};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pix_clk);
    @(negedge pix_clk);
  endtask

  task automatic send_cfg(input logic [47:0] h, input logic [47:0] v, input logic [7:0] pat);
    cfg_h       = h;
    cfg_v       = v;
    cfg_pattern = pat;
    cfg_valid   = 1'b1;
    tick(1);
    cfg_valid   = 1'b0;
  endtask

  logic [47:0]  h_def, v_def, h_720, v_720, h_b, v_b;
  logic [255:0] t_exp;
  logic [31:0]  c_exp;

  initial begin
    h_def = pack4(800, 784, 144, 96);
    v_def = pack4(525, 515, 35, 2);
    h_720 = pack4(1650, 1540, 260, 40);
    v_720 = pack4(750, 745, 25, 5);
    h_b   = pack4(1344, 1320, 296, 136);
    v_b   = pack4(806, 803, 35, 6);

    vecs[0] = '{h: h_720, v: v_720, pat: 8'h03, ok: 1'b1};
    vecs[1] = '{h: pack4(800, 784, 144, 0), v: v_def, pat: 8'h07, ok: 1'b0};
    vecs[2] = '{h: pack4(800, 784, 144, 144), v: v_def, pat: 8'h07, ok: 1'b0};
    vecs[3] = '{h: h_def, v: pack4(525, 526, 35, 2), pat: 8'h07, ok: 1'b0};
    vecs[4] = '{h: h_def, v: v_def, pat: 8'h00, ok: 1'b1};
    vecs[5] = '{h: h_def, v: pack4(525, 515, 2, 2), pat: 8'h07, ok: 1'b0};
    vecs[6] = '{h: pack4(3, 3, 2, 1), v: pack4(3, 3, 2, 1), pat: 8'h11, ok: 1'b1};
    vecs[7] = '{h: pack4(4095, 4094, 4093, 4092), v: pack4(100, 99, 50, 1), pat: 8'hA5, ok: 1'b1};

    areset = 1'b1; pix_clk_locked = 1'b1; en_req = 1'b0; cfg_valid = 1'b0;
    cfg_h = '0; cfg_v = '0; cfg_pattern = '0; vsync = 1'b0;
    tick(3);
    areset = 1'b0;
    tick(1);

    // Reset state
    check("rst_ctrl", 256'(ctrl), 256'(0));
    check("rst_state", 256'(state), 256'(S_OFF));
    check("rst_cfg_ready", 256'(cfg_ready), 256'(1));
    check("rst_pulses", 256'({cfg_applied, cfg_err}), 256'(0));
    check("rst_lock_lost", 256'(lock_lost), 256'(0));
    check("rst_frame_cnt", 256'(frame_cnt), 256'(0));
    check("rst_timing", timing_now(), exp_timing(h_def, v_def));

    // Enable after settle: ctrl[0] rises exactly SETTLE+1 cycles after en_req
    en_req = 1'b1;
    tick(1);
    check("settle_state", 256'(state), 256'(S_SETTLE));
    check("settle_cfg_ready", 256'(cfg_ready), 256'(0));
    tick(SETTLE - 1);
    check("settle_en_not_yet", 256'(ctrl[0]), 256'(0));
    tick(1);
    check("settle_en_rise", 256'(ctrl), 256'(32'h1));
    check("settle_run", 256'(state), 256'(S_RUN));
    check("run_timing_def", timing_now(), exp_timing(h_def, v_def));

    // Three frames in RUN
    for (int i = 0; i < 3; i++) begin
      vsync = 1'b1; tick(1);
      vsync = 1'b0; tick(1);
    end
    check("frame_cnt_3", 256'(frame_cnt), 256'(3));

    // 720p config in RUN, applied only after the next vsync rise
    send_cfg(h_720, v_720, 8'h03);
    check("pend_state", 256'(state), 256'(S_PEND));
    check("pend_cfg_ready", 256'(cfg_ready), 256'(0));
    check("pend_timing_hold", timing_now(), exp_timing(h_def, v_def));
    tick(3);
    check("pend_timing_hold2", timing_now(), exp_timing(h_def, v_def));
    check("pend_ctrl_hold", 256'(ctrl), 256'(32'h1));
    vsync = 1'b1;
    tick(1);
    check("apply_timing", timing_now(), exp_timing(h_720, v_720));
    check("apply_ctrl", 256'(ctrl), 256'(32'h0000_0301));
    check("apply_pulse", 256'(cfg_applied), 256'(1));
    check("apply_state", 256'(state), 256'(S_RUN));
    check("apply_frame_cnt", 256'(frame_cnt), 256'(4));
    vsync = 1'b0;
    tick(1);
    check("apply_pulse_once", 256'(cfg_applied), 256'(0));

    // Invalid config in RUN: hs_end 200 > hbp_end 144
    send_cfg(pack4(800, 784, 144, 200), v_def, 8'h09);
    check("bad_err", 256'(cfg_err), 256'(1));
    check("bad_state", 256'(state), 256'(S_RUN));
    check("bad_ready", 256'(cfg_ready), 256'(1));
    check("bad_timing", timing_now(), exp_timing(h_720, v_720));
    check("bad_ctrl", 256'(ctrl), 256'(32'h0000_0301));
    tick(1);
    check("bad_err_once", 256'(cfg_err), 256'(0));

    // Frame counter wrap from 0xFFFF
    force dut.frame_cnt_d = 16'hFFFF;
    tick(1);
    release dut.frame_cnt_d;
    check("wrap_preload", 256'(frame_cnt), 256'(16'hFFFF));
    vsync = 1'b1; tick(1);
    check("wrap_zero", 256'(frame_cnt), 256'(0));
    vsync = 1'b0; tick(1);

    // Lock loss in PEND keeps the staged config for the next enable
    send_cfg(h_b, v_b, 8'h05);
    check("ll_pend", 256'(state), 256'(S_PEND));
    pix_clk_locked = 1'b0;
    tick(1);
    check("ll_state", 256'(state), 256'(S_OFF));
    check("ll_en", 256'(ctrl[0]), 256'(0));
    check("ll_sticky", 256'(lock_lost), 256'(1));
    check("ll_timing", timing_now(), exp_timing(h_720, v_720));
    tick(2);
    check("ll_sticky_hold", 256'(lock_lost), 256'(1));
    pix_clk_locked = 1'b1;
    tick(1);
    check("relock_settle", 256'(state), 256'(S_SETTLE));
    check("relock_clear", 256'(lock_lost), 256'(0));
    tick(SETTLE - 1);
    check("relock_not_yet", 256'(ctrl[0]), 256'(0));
    tick(1);
    check("relock_state", 256'(state), 256'(S_RUN));
    check("relock_ctrl", 256'(ctrl), 256'(32'h0000_0501));
    check("relock_timing", timing_now(), exp_timing(h_b, v_b));

    // en_req drop with vsync idle: STOP holds enable for STOPTO cycles
    en_req = 1'b0;
    tick(1);
    check("stop_state", 256'(state), 256'(S_STOP));
    check("stop_en_first", 256'(ctrl[0]), 256'(1));
    tick(STOPTO - 1);
    check("stop_en_last", 256'(ctrl[0]), 256'(1));
    check("stop_state_last", 256'(state), 256'(S_STOP));
    tick(1);
    check("stop_en_clear", 256'(ctrl[0]), 256'(0));
    check("stop_off", 256'(state), 256'(S_OFF));

    // OFF-state config table: valid ones land on outputs one cycle later
    t_exp = exp_timing(h_b, v_b);
    c_exp = 32'h0000_0500;
    for (int i = 0; i < 8; i++) begin
      send_cfg(vecs[i].h, vecs[i].v, vecs[i].pat);
      if (vecs[i].ok) begin
        t_exp = exp_timing(vecs[i].h, vecs[i].v);
        c_exp = {16'h0, vecs[i].pat, 8'h00};
      end
      check($sformatf("tbl%0d_applied", i), 256'(cfg_applied), 256'(vecs[i].ok));
      check($sformatf("tbl%0d_err", i), 256'(cfg_err), 256'(!vecs[i].ok));
      check($sformatf("tbl%0d_timing", i), timing_now(), t_exp);
      check($sformatf("tbl%0d_ctrl", i), 256'(ctrl), 256'(c_exp));
      check($sformatf("tbl%0d_state", i), 256'(state), 256'(S_OFF));
    end

    // Asynchronous reset in SETTLE acts without waiting for a clock edge
    en_req = 1'b1;
    tick(2);
    check("ar_pre_state", 256'(state), 256'(S_SETTLE));
    #2 areset = 1'b1;
    #1;
    check("ar_state", 256'(state), 256'(S_OFF));
    check("ar_ctrl", 256'(ctrl), 256'(0));
    check("ar_timing", timing_now(), exp_timing(h_def, v_def));
    check("ar_ready", 256'(cfg_ready), 256'(1));
    tick(1);
    areset = 1'b0;
    en_req = 1'b0;
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
